// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and the count direction type.
package gray_pkg;

  // Widest counter the helpers support; narrower values are zero-extended.
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down. Zero-extension leaves the upper bits at
  // zero, so the low bits match a conversion done at the native width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin                 = '0;
    bin[GRAY_MAX_W-1]   = gray[GRAY_MAX_W-1];
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      bin[GRAY_MAX_W-1-i] = bin[GRAY_MAX_W-i] ^ gray[GRAY_MAX_W-1-i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin.sv
// Combinational WIDTH-bit Gray-to-binary converter for the load path.
module gray2bin_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Same prefix-XOR algorithm as the package function, at this width.
  always_comb begin
    b = WIDTH'(gray2bin(GRAY_MAX_W'(g)));
  end

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code up/down counter with load, binary shadow count,
// terminal-count and wrap indications.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             wrap
);

  localparam bit SATURATE = (WRAP == 0);

  count_dir_e       dir;
  logic             at_end;
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] g_d;
  logic             wrap_d;

  assign dir = count_dir_e'(up_dn);

  gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
    .g (load_g),
    .b (load_b)
  );

  // Range end in the current direction; doubles as tc regardless of en.
  always_comb begin
    at_end = (dir == DIR_UP) ? (b == '1) : (b == '0);
    tc     = at_end;
  end

  // Next-state selection: load beats count; g is always derived alongside b.
  always_comb begin
    b_d    = b;
    g_d    = g;
    wrap_d = 1'b0;
    if (load) begin
      b_d = load_b;
      g_d = load_g;
    end else if (en && !(at_end && SATURATE)) begin
      b_d    = (dir == DIR_UP) ? b + WIDTH'(1) : b - WIDTH'(1);
      g_d    = WIDTH'(bin2gray(GRAY_MAX_W'(b_d)));
      wrap_d = at_end;
    end
  end

  // State registers with synchronous reset taking top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      b    <= '0;
      g    <= '0;
      wrap <= 1'b0;
    end else begin
      b    <= b_d;
      g    <= g_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: a wrapping and a saturating instance share
// one stimulus stream; per-cycle invariant and one-bit-step checks run alongside.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [2:0] load_g;
  logic [2:0] gw, bw, gs, bs;
  logic       tcw, wrapw, tcs, wraps;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  logic [2:0] prev_gw, prev_gs;
  bit         cstep = 1'b0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(3), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_g(load_g),
    .g(gw), .b(bw), .tc(tcw), .wrap(wrapw)
  );

  gray_counter #(.WIDTH(3), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_g(load_g),
    .g(gs), .b(bs), .tc(tcs), .wrap(wraps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture pre-edge Gray values and whether this edge is a count step.
  always @(posedge clk) begin
    prev_gw <= gw;
    prev_gs <= gs;
    cstep   <= !rst && !load && en;
  end

  // Every cycle: g consistent with b, and count steps change exactly one bit.
  always @(negedge clk) begin
    if (checking) begin
      chk("w_invariant", 32'(gw), 32'(bw ^ (bw >> 1)));
      chk("s_invariant", 32'(gs), 32'(bs ^ (bs >> 1)));
      if (cstep && gw !== prev_gw) chk("w_onebit", 32'($countones(gw ^ prev_gw)), 32'd1);
      if (cstep && gs !== prev_gs) chk("s_onebit", 32'($countones(gs ^ prev_gs)), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] eg [8];
    logic [2:0] eb [8];
    eg = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    eb = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    // Reset for two cycles
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_g = 3'b000;
    step(); step();
    chk("rst_g", 32'(gw), 32'd0);
    chk("rst_b", 32'(bw), 32'd0);
    chk("rst_wrap", 32'(wrapw), 32'd0);
    chk("rst_tc", 32'(tcw), 32'd0);
    chk("rst_s_g", 32'(gs), 32'd0);
    checking = 1'b1;

    // Count up through a full cycle
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("up_g", 32'(gw), 32'(eg[i]));
      chk("up_b", 32'(bw), 32'(eb[i]));
      chk("up_wrap", 32'(wrapw), (i == 7) ? 32'd1 : 32'd0);
      chk("up_tc", 32'(tcw), (i == 6) ? 32'd1 : 32'd0);
      chk("sat_g", 32'(gs), (i == 7) ? 32'(3'b100) : 32'(eg[i]));
      chk("sat_wrap", 32'(wraps), 32'd0);
    end

    // Saturating instance holds at the top; wrapping one keeps counting
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_hold_g", 32'(gs), 32'(3'b100));
      chk("sat_hold_b", 32'(bs), 32'd7);
      chk("sat_hold_wrap", 32'(wraps), 32'd0);
      chk("sat_hold_tc", 32'(tcs), 32'd1);
      chk("w_after_g", 32'(gw), 32'(eg[i]));
    end

    // Reset mid-count at g=010, then release with en=1
    chk("pre_rst_g", 32'(gw), 32'(3'b010));
    rst = 1'b1;
    step();
    chk("midrst_g", 32'(gw), 32'd0);
    chk("midrst_b", 32'(bw), 32'd0);
    chk("midrst_s_g", 32'(gs), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_g", 32'(gw), 32'(3'b001));
    chk("rel_s_g", 32'(gs), 32'(3'b001));

    // Count down to zero, then across the bottom
    up_dn = 1'b0;
    step();
    chk("dn0_g", 32'(gw), 32'd0);
    chk("dn0_tc", 32'(tcw), 32'd1);
    step();
    chk("dnwrap_g", 32'(gw), 32'(3'b100));
    chk("dnwrap_b", 32'(bw), 32'd7);
    chk("dnwrap_wrap", 32'(wrapw), 32'd1);
    chk("dnsat_g", 32'(gs), 32'd0);
    chk("dnsat_wrap", 32'(wraps), 32'd0);
    step();
    chk("dn_next_g", 32'(gw), 32'(3'b101));
    chk("dn_next_b", 32'(bw), 32'd6);
    chk("dn_next_wrap", 32'(wrapw), 32'd0);

    // Load wins over en
    load = 1'b1; load_g = 3'b110;
    step();
    chk("load_g", 32'(gw), 32'(3'b110));
    chk("load_b", 32'(bw), 32'd4);
    chk("load_wrap", 32'(wrapw), 32'd0);
    chk("load_s_b", 32'(bs), 32'd4);
    load_g = 3'b011;
    step();
    chk("load2_b", 32'(bw), 32'd2);

    // Reset during a load
    rst = 1'b1; load_g = 3'b111;
    step();
    chk("rstload_g", 32'(gw), 32'd0);
    chk("rstload_b", 32'(bw), 32'd0);

    // Idle hold, and tc follows up_dn combinationally
    rst = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1;
    step();
    chk("idle_g", 32'(gw), 32'd0);
    chk("idle_tc_up", 32'(tcw), 32'd0);
    up_dn = 1'b0;
    #1;
    chk("idle_tc_dn", 32'(tcw), 32'd1);
    step();
    chk("idle_hold_g", 32'(gw), 32'd0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
